// File: rtl/add_sub_serial.sv
// Chunk-serial adder/subtractor: ADD, SUB, ADC and SBC over SIZE bits, CHUNK bits per clock,
// with a start/busy/done handshake and full result flags.
module add_sub_serial #(
    parameter int SIZE  = 16,
    parameter int CHUNK = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic            cin,
    input  logic [SIZE-1:0] in_a,
    input  logic [SIZE-1:0] in_b,
    output logic            busy,
    output logic            done,
    output logic [SIZE-1:0] out,
    output logic            cout,
    output logic            negative,
    output logic            zero,
    output logic            overflow
);

    localparam int NChunk = SIZE / CHUNK;
    localparam int CntW   = (NChunk > 1) ? $clog2(NChunk) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(NChunk - 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [SIZE-1:0] a_q, a_d;
    logic [SIZE-1:0] b_q, b_d;
    logic            c_q, c_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [SIZE-1:0] acc_q, acc_d;
    logic            a_msb_q, a_msb_d;
    logic            b_msb_q, b_msb_d;
    logic [SIZE-1:0] out_q, out_d;
    logic            cout_q, cout_d;
    logic            neg_q, neg_d;
    logic            zero_q, zero_d;
    logic            ovf_q, ovf_d;

    logic [CHUNK:0]  sum;
    logic [SIZE-1:0] acc_shift;

    // Operands shift right each chunk, so the active chunk is always the low slice.
    assign sum = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, c_q};

    // Result fills from the top, landing in place after the last chunk.
    if (CHUNK == SIZE) begin : g_single
        assign acc_shift = sum[CHUNK-1:0];
    end else begin : g_multi
        assign acc_shift = {sum[CHUNK-1:0], acc_q[SIZE-1:CHUNK]};
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        out_d   = out_q;
        cout_d  = cout_q;
        neg_d   = neg_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;

        case (state_q)
            StRun: begin
                a_d   = a_q >> CHUNK;
                b_d   = b_q >> CHUNK;
                c_d   = sum[CHUNK];
                acc_d = acc_shift;
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == LastCnt) begin
                    state_d = StDone;
                    out_d   = acc_shift;
                    cout_d  = sum[CHUNK];
                    neg_d   = acc_shift[SIZE-1];
                    zero_d  = (acc_shift == '0);
                    ovf_d   = (a_msb_q == b_msb_q) && (acc_shift[SIZE-1] != a_msb_q);
                end
            end
            default: begin
                if (start) begin
                    state_d = StRun;
                    a_d     = in_a;
                    b_d     = op[0] ? ~in_b : in_b;
                    // ADD: 0, SUB: 1, ADC/SBC: external carry
                    c_d     = op[1] ? cin : op[0];
                    cnt_d   = '0;
                    a_msb_d = in_a[SIZE-1];
                    b_msb_d = op[0] ? ~in_b[SIZE-1] : in_b[SIZE-1];
                end else begin
                    state_d = StIdle;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            acc_q   <= '0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            out_q   <= '0;
            cout_q  <= 1'b0;
            neg_q   <= 1'b0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            out_q   <= out_d;
            cout_q  <= cout_d;
            neg_q   <= neg_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy     = (state_q == StRun);
    assign done     = (state_q == StDone);
    assign out      = out_q;
    assign cout     = cout_q;
    assign negative = neg_q;
    assign zero     = zero_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_add_sub_serial.sv
// Bench for add_sub_serial: a 4-bit-chunk instance and a single-pass instance share stimulus;
// results are checked against an integer-arithmetic model.
module tb_add_sub_serial;

    localparam logic [1:0] OpAdd = 2'b00;
    localparam logic [1:0] OpSub = 2'b01;
    localparam logic [1:0] OpAdc = 2'b10;
    localparam logic [1:0] OpSbc = 2'b11;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic        cin;
    logic [15:0] in_a;
    logic [15:0] in_b;

    logic        busy4, done4, cout4, neg4, zero4, ovf4;
    logic [15:0] out4;
    logic        busy16, done16, cout16, neg16, zero16, ovf16;
    logic [15:0] out16;

    int checks;
    int failures;

    add_sub_serial #(.SIZE(16), .CHUNK(4)) u_dut4 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .cin      (cin),
        .in_a     (in_a),
        .in_b     (in_b),
        .busy     (busy4),
        .done     (done4),
        .out      (out4),
        .cout     (cout4),
        .negative (neg4),
        .zero     (zero4),
        .overflow (ovf4)
    );

    add_sub_serial #(.SIZE(16), .CHUNK(16)) u_dut16 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .cin      (cin),
        .in_a     (in_a),
        .in_b     (in_b),
        .busy     (busy16),
        .done     (done16),
        .out      (out16),
        .cout     (cout16),
        .negative (neg16),
        .zero     (zero16),
        .overflow (ovf16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    // Returns {cout, negative, zero, overflow, out}
    function automatic logic [19:0] model(input logic [1:0] o, input logic [15:0] a,
                                          input logic [15:0] b, input logic ci);
        int c, full, sres;
        logic [15:0] r;
        logic co, ov;
        c = (o == OpAdd) ? 0 : (o == OpSub) ? 1 : int'(ci);
        if (o[0]) begin
            full = int'(a) - int'(b) - (1 - c);
            sres = int'($signed(a)) - int'($signed(b)) - (1 - c);
            co   = (full >= 0);
        end else begin
            full = int'(a) + int'(b) + c;
            sres = int'($signed(a)) + int'($signed(b)) + c;
            co   = (full > 65535);
        end
        r  = full[15:0];
        ov = (sres > 32767) || (sres < -32768);
        return {co, r[15], (r == 16'h0000), ov, r};
    endfunction

    function automatic logic [19:0] obs4();
        return {cout4, neg4, zero4, ovf4, out4};
    endfunction

    function automatic logic [19:0] obs16();
        return {cout16, neg16, zero16, ovf16, out16};
    endfunction

    // Issue one operation and count clock edges from accept until done (bounded).
    task automatic do_op(input int which, input logic [1:0] o, input logic [15:0] a,
                         input logic [15:0] b, input logic ci, output int lat);
        @(negedge clk);
        op = o; in_a = a; in_b = b; cin = ci; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (!((which == 1) ? done16 : done4) && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; op = 2'b00; cin = 1'b0; in_a = '0; in_b = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy4, done4, obs4()} !== 22'h0) begin
            failures++;
            $display("FAIL reset_state got=%h exp=0", {busy4, done4, obs4()});
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy4, done4, obs4(), busy16, done16, obs16()} !== 44'h0) begin
            failures++;
            $display("FAIL idle_after_reset got=%h exp=0",
                     {busy4, done4, obs4(), busy16, done16, obs16()});
        end
    endtask

    task automatic test_add_sub();
        int lat;
        do_op(0, OpAdd, 16'h7FFF, 16'h0001, 1'b0, lat);
        checks++;
        if (lat !== 4) begin
            failures++; $display("FAIL add_latency got=%0d exp=4", lat);
        end
        checks++;
        if (obs4() !== {1'b0, 1'b1, 1'b0, 1'b1, 16'h8000}) begin
            failures++; $display("FAIL add_ovf got=%h exp=%h", obs4(), {4'b0101, 16'h8000});
        end
        do_op(0, OpSub, 16'h0005, 16'h0005, 1'b0, lat);
        checks++;
        if (obs4() !== {1'b1, 1'b0, 1'b1, 1'b0, 16'h0000}) begin
            failures++; $display("FAIL sub_zero got=%h exp=%h", obs4(), {4'b1010, 16'h0000});
        end
        do_op(0, OpSub, 16'h0003, 16'h0005, 1'b0, lat);
        checks++;
        if (obs4() !== {1'b0, 1'b1, 1'b0, 1'b0, 16'hFFFE}) begin
            failures++; $display("FAIL sub_borrow got=%h exp=%h", obs4(), {4'b0100, 16'hFFFE});
        end
    endtask

    task automatic test_chain();
        int lat;
        do_op(0, OpAdc, 16'hFFFF, 16'h0001, 1'b0, lat);
        checks++;
        if (obs4() !== {1'b1, 1'b0, 1'b1, 1'b0, 16'h0000}) begin
            failures++; $display("FAIL adc_low got=%h exp=%h", obs4(), {4'b1010, 16'h0000});
        end
        do_op(0, OpAdc, 16'h0001, 16'h0000, cout4, lat);
        checks++;
        if (obs4() !== {1'b0, 1'b0, 1'b0, 1'b0, 16'h0002}) begin
            failures++; $display("FAIL adc_high got=%h exp=%h", obs4(), {4'b0000, 16'h0002});
        end
        do_op(0, OpSbc, 16'h0000, 16'h0000, 1'b0, lat);
        checks++;
        if (obs4() !== {1'b0, 1'b1, 1'b0, 1'b0, 16'hFFFF}) begin
            failures++; $display("FAIL sbc_borrow got=%h exp=%h", obs4(), {4'b0100, 16'hFFFF});
        end
    endtask

    task automatic test_random();
        int lat;
        logic [1:0]  o;
        logic [15:0] a, b;
        logic        ci;
        logic [19:0] exp;
        for (int i = 0; i < 30; i++) begin
            o  = 2'($urandom_range(0, 3));
            a  = 16'($urandom);
            b  = 16'($urandom);
            ci = 1'($urandom);
            if (i % 8 == 0) a = 16'h8000;
            if (i % 8 == 1) b = 16'h7FFF;
            exp = model(o, a, b, ci);
            do_op(0, o, a, b, ci, lat);
            checks++;
            if (lat !== 4) begin
                failures++; $display("FAIL rand_latency[%0d] got=%0d exp=4", i, lat);
            end
            checks++;
            if (obs4() !== exp) begin
                failures++;
                $display("FAIL rand_result[%0d] op=%0d a=%h b=%h cin=%b got=%h exp=%h",
                         i, o, a, b, ci, obs4(), exp);
            end
            @(negedge clk);
            checks++;
            if (done4 !== 1'b0 || obs4() !== exp) begin
                failures++;
                $display("FAIL rand_pulse_hold[%0d] done=%b got=%h exp=%h", i, done4, obs4(), exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        int cnt, c2, early_done;
        @(negedge clk);
        op = OpAdd; in_a = 16'h1234; in_b = 16'h1111; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        early_done = 0;
        @(negedge clk);
        early_done += int'(done4);
        op = OpSub; in_a = 16'hAAAA; in_b = 16'h5555; start = 1'b1;
        @(negedge clk);
        early_done += int'(done4);
        in_a = 16'h0F0F; start = 1'b1;
        @(negedge clk);
        early_done += int'(done4);
        start = 1'b0; in_a = 16'hFFFF;
        cnt = 2;
        while (!done4 && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        checks++;
        if (cnt !== 4 || early_done !== 0) begin
            failures++;
            $display("FAIL ignore_start_latency got=%0d early=%0d exp=4/0", cnt, early_done);
        end
        checks++;
        if (obs4() !== {4'b0000, 16'h2345}) begin
            failures++; $display("FAIL ignore_start_result got=%h exp=%h", obs4(), {4'b0, 16'h2345});
        end
        checks++;
        if (busy4 !== 1'b0) begin
            failures++; $display("FAIL busy_in_done got=%b exp=0", busy4);
        end
        op = OpAdd; in_a = 16'h0001; in_b = 16'h0002; start = 1'b1;
        c2 = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            c2++;
        end while (!done4 && c2 < 40);
        checks++;
        if (c2 !== 5) begin
            failures++; $display("FAIL b2b_spacing got=%0d exp=5", c2);
        end
        checks++;
        if (obs4() !== {4'b0000, 16'h0003}) begin
            failures++; $display("FAIL b2b_result got=%h exp=%h", obs4(), {4'b0, 16'h0003});
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int lat, seen;
        do_op(0, OpAdd, 16'h1200, 16'h0034, 1'b0, lat);
        checks++;
        if (obs4() !== {4'b0000, 16'h1234}) begin
            failures++; $display("FAIL pre_reset_result got=%h exp=%h", obs4(), {4'b0, 16'h1234});
        end
        @(negedge clk);
        op = OpSub; in_a = 16'h4321; in_b = 16'h0123; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy4, done4, obs4()} !== 22'h0) begin
            failures++; $display("FAIL async_reset got=%h exp=0", {busy4, done4, obs4()});
        end
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            seen += int'(done4);
        end
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            seen += int'(done4);
        end
        checks++;
        if (seen !== 0) begin
            failures++; $display("FAIL reset_no_done got=%0d exp=0", seen);
        end
        do_op(0, OpSub, 16'h1000, 16'h0001, 1'b0, lat);
        checks++;
        if (lat !== 4 || obs4() !== {4'b1000, 16'h0FFF}) begin
            failures++;
            $display("FAIL post_reset_sub lat=%0d got=%h exp=4/%h", lat, obs4(), {4'b1000, 16'h0FFF});
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_pass();
        int lat;
        do_op(1, OpSub, 16'h8000, 16'h0001, 1'b0, lat);
        checks++;
        if (lat !== 1) begin
            failures++; $display("FAIL single_latency got=%0d exp=1", lat);
        end
        checks++;
        if (obs16() !== {1'b1, 1'b0, 1'b0, 1'b1, 16'h7FFF}) begin
            failures++; $display("FAIL single_result got=%h exp=%h", obs16(), {4'b1001, 16'h7FFF});
        end
        repeat (6) @(negedge clk);
        do_op(1, OpAdc, 16'hFFFE, 16'h0001, 1'b1, lat);
        checks++;
        if (lat !== 1 || obs16() !== model(OpAdc, 16'hFFFE, 16'h0001, 1'b1)) begin
            failures++;
            $display("FAIL single_adc lat=%0d got=%h exp=%h", lat, obs16(),
                     model(OpAdc, 16'hFFFE, 16'h0001, 1'b1));
        end
        repeat (6) @(negedge clk);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_add_sub();
        test_chain();
        test_random();
        test_back_to_back();
        test_reset_mid();
        test_single_pass();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
